// File: rtl/toy_bpu_rob_mc_pkg.sv
// Shared types and defaults for the multi-channel fetch reorder buffer.
// Holds the per-entry state encoding used by the top level and by each entry.
package toy_pack;

    localparam int ROB_DEPTH        = 8;
    localparam int FETCH_DATA_WIDTH = 128;
    localparam int ROB_ACK_PORTS    = 2;

    typedef logic [$clog2(ROB_DEPTH)-1:0] rob_id_t;

    typedef enum logic [2:0] {
        ROB_FREE   = 3'd0,
        ROB_WAIT   = 3'd1,
        ROB_DONE   = 3'd2,
        ROB_KWAIT  = 3'd3,
        ROB_KILLED = 3'd4,
        ROB_ORPHAN = 3'd5
    } rob_state_e;

endpackage

// File: rtl/toy_bpu_rob_mc_if.sv
// Front-end bus around the fetch ROB: PC-gen alloc, icache return channels,
// BP2 kill, flush and the in-order output towards the fetch filter.
interface toy_bpu_rob_mc_if
    import toy_pack::*;
#(
    parameter int DEPTH     = ROB_DEPTH,
    parameter int DATA_W    = FETCH_DATA_WIDTH,
    parameter int ACK_PORTS = ROB_ACK_PORTS
);
    localparam int ID_W = $clog2(DEPTH);

    logic                        alloc_req;
    logic                        alloc_rdy;
    logic [ID_W-1:0]             alloc_id;
    logic [ACK_PORTS-1:0]        ack_vld;
    logic [ACK_PORTS*ID_W-1:0]   ack_id;
    logic [ACK_PORTS*DATA_W-1:0] ack_pld;
    logic [ACK_PORTS-1:0]        ack_rdy;
    logic                        bp2_vld;
    logic                        bp2_kill;
    logic                        flush;
    logic                        flush_done;
    logic                        out_vld;
    logic                        out_rdy;
    logic [DATA_W-1:0]           out_pld;
    logic [ID_W-1:0]             out_id;

    modport master (
        output alloc_req, ack_vld, ack_id, ack_pld, bp2_vld, bp2_kill, flush, out_rdy,
        input  alloc_rdy, alloc_id, ack_rdy, flush_done, out_vld, out_pld, out_id
    );

    modport slave (
        input  alloc_req, ack_vld, ack_id, ack_pld, bp2_vld, bp2_kill, flush, out_rdy,
        output alloc_rdy, alloc_id, ack_rdy, flush_done, out_vld, out_pld, out_id
    );

endinterface

// File: rtl/toy_bpu_rob_mc_entry.sv
// One fetch ROB slot: lifecycle state plus the fetch block payload.
// Flush overrides every other strobe; an ack in the flush cycle frees a pending slot.
module toy_bpu_rob_mc_entry
    import toy_pack::*;
#(
    parameter int DATA_W = FETCH_DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc,
    input  logic              alloc_kill,
    input  logic              ack,
    input  logic              kill,
    input  logic              flush,
    input  logic              free,
    input  logic [DATA_W-1:0] ack_pld,
    output rob_state_e        state,
    output logic [DATA_W-1:0] pld
);

    rob_state_e state_q;
    rob_state_e state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ROB_FREE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pld <= '0;
        end else if (ack && (state_q == ROB_WAIT || state_q == ROB_KWAIT)) begin
            pld <= ack_pld;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            case (state_q)
                ROB_WAIT,
                ROB_KWAIT:  state_d = ack ? ROB_FREE : ROB_ORPHAN;
                ROB_DONE,
                ROB_KILLED: state_d = ROB_FREE;
                ROB_ORPHAN: if (ack) state_d = ROB_FREE;
                default:    state_d = state_q;
            endcase
        end else begin
            case (state_q)
                ROB_FREE: begin
                    if (alloc) state_d = alloc_kill ? ROB_KWAIT : ROB_WAIT;
                end
                ROB_WAIT: begin
                    if (ack)       state_d = kill ? ROB_KILLED : ROB_DONE;
                    else if (kill) state_d = ROB_KWAIT;
                end
                ROB_KWAIT: begin
                    if (ack) state_d = ROB_KILLED;
                end
                // A block already handed to the filter cannot be retracted, so dequeue beats kill
                ROB_DONE: begin
                    if (free)      state_d = ROB_FREE;
                    else if (kill) state_d = ROB_KILLED;
                end
                ROB_KILLED: begin
                    if (free) state_d = ROB_FREE;
                end
                ROB_ORPHAN: begin
                    if (ack) state_d = ROB_FREE;
                end
                default: state_d = ROB_FREE;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: rtl/toy_bpu_rob_mc.sv
// Multi-channel fetch reorder buffer: in-order delivery of out-of-order icache returns.
// Optional TOY_BPU_ROB_SKIP2_EN lets the head retire two entries per cycle past killed slots.
module toy_bpu_rob_mc
    import toy_pack::*;
#(
    parameter int DEPTH     = ROB_DEPTH,
    parameter int DATA_W    = FETCH_DATA_WIDTH,
    parameter int ACK_PORTS = ROB_ACK_PORTS
) (
    input  logic             clk,
    input  logic             rst_n,
    toy_bpu_rob_mc_if.slave  bus
);

    localparam int ID_W  = $clog2(DEPTH);
    localparam int PTR_W = ID_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [ID_W-1:0]  idx_t;

    ptr_t wr_ptr;
    ptr_t rd_ptr;
    idx_t wr_idx;
    idx_t head_idx;
    idx_t kill_idx;
    idx_t pair_idx;

    logic empty;
    logic full;
    logic alloc_rdy;
    logic alloc_fire;
    logic kill_fire;
    logic out_vld;
    logic head_deq;
    logic head_skip;
    logic pair;

    rob_state_e        ent_state   [DEPTH];
    logic [DATA_W-1:0] ent_pld     [DEPTH];
    logic [DATA_W-1:0] ent_ack_pld [DEPTH];
    logic [DEPTH-1:0]  ent_alloc;
    logic [DEPTH-1:0]  ent_ack;
    logic [DEPTH-1:0]  ent_kill;
    logic [DEPTH-1:0]  ent_free;
    logic [DEPTH-1:0]  orphan;

    assign wr_idx   = wr_ptr[ID_W-1:0];
    assign head_idx = rd_ptr[ID_W-1:0];
    assign kill_idx = idx_t'(wr_ptr - ptr_t'(1));

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ID_W-1:0] == rd_ptr[ID_W-1:0]) && (wr_ptr[ID_W] != rd_ptr[ID_W]);

    // Orphaned slots stay non-FREE until their late data drains, which stalls PC-gen
    assign alloc_rdy  = !full && (ent_state[wr_idx] == ROB_FREE) && !bus.flush;
    assign alloc_fire = bus.alloc_req && alloc_rdy;
    assign kill_fire  = bus.bp2_vld && bus.bp2_kill && !empty && !bus.flush;

    assign out_vld   = !empty && (ent_state[head_idx] == ROB_DONE);
    assign head_deq  = out_vld && bus.out_rdy && !bus.flush;
    assign head_skip = !empty && (ent_state[head_idx] == ROB_KILLED) && !bus.flush;

`ifdef TOY_BPU_ROB_SKIP2_EN
    logic next_in_q;

    always_comb begin
        pair_idx  = idx_t'(rd_ptr + ptr_t'(1));
        next_in_q = ((rd_ptr + ptr_t'(1)) != wr_ptr);
        pair      = (head_deq || head_skip) && next_in_q && (ent_state[pair_idx] == ROB_KILLED);
    end
`else
    always_comb begin
        pair_idx = head_idx;
        pair     = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (alloc_fire) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
            end
            if (bus.flush) begin
                rd_ptr <= wr_ptr;
            end else if (pair) begin
                rd_ptr <= rd_ptr + ptr_t'(2);
            end else if (head_deq || head_skip) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
        end
    end

    // Lower-numbered return channel wins when two channels name the same entry
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_ack[i]     = 1'b0;
            ent_ack_pld[i] = '0;
            for (int p = ACK_PORTS - 1; p >= 0; p--) begin
                if (bus.ack_vld[p] && (bus.ack_id[p*ID_W +: ID_W] == idx_t'(i))) begin
                    ent_ack[i]     = 1'b1;
                    ent_ack_pld[i] = bus.ack_pld[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_alloc[i] = alloc_fire && (wr_idx == idx_t'(i));
            ent_kill[i]  = kill_fire && (kill_idx == idx_t'(i));
            ent_free[i]  = ((head_deq || head_skip) && (head_idx == idx_t'(i))) ||
                           (pair && (pair_idx == idx_t'(i)));
            orphan[i]    = (ent_state[i] == ROB_ORPHAN);
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        toy_bpu_rob_mc_entry #(
            .DATA_W (DATA_W)
        ) u_ent (
            .clk        (clk),
            .rst_n      (rst_n),
            .alloc      (ent_alloc[i]),
            .alloc_kill (bus.bp2_vld && bus.bp2_kill),
            .ack        (ent_ack[i]),
            .kill       (ent_kill[i]),
            .flush      (bus.flush),
            .free       (ent_free[i]),
            .ack_pld    (ent_ack_pld[i]),
            .state      (ent_state[i]),
            .pld        (ent_pld[i])
        );
    end

    assign bus.alloc_rdy  = alloc_rdy;
    assign bus.alloc_id   = wr_idx;
    assign bus.ack_rdy    = '1;
    assign bus.flush_done = ~|orphan;
    assign bus.out_vld    = out_vld;
    assign bus.out_pld    = ent_pld[head_idx];
    assign bus.out_id     = head_idx;

    // Protocol checks on the icache return channels
    logic [ACK_PORTS-1:0] ack_bad;
    logic                 ack_dup;

    always_comb begin
        ack_dup = 1'b0;
        for (int p = 0; p < ACK_PORTS; p++) begin
            ack_bad[p] = bus.ack_vld[p] &&
                         ((ent_state[bus.ack_id[p*ID_W +: ID_W]] == ROB_FREE) ||
                          (ent_state[bus.ack_id[p*ID_W +: ID_W]] == ROB_DONE) ||
                          (ent_state[bus.ack_id[p*ID_W +: ID_W]] == ROB_KILLED));
            for (int q = p + 1; q < ACK_PORTS; q++) begin
                if (bus.ack_vld[p] && bus.ack_vld[q] &&
                    (bus.ack_id[p*ID_W +: ID_W] == bus.ack_id[q*ID_W +: ID_W])) begin
                    ack_dup = 1'b1;
                end
            end
        end
    end

    a_ack_state_ok: assert property (@(posedge clk) disable iff (!rst_n) ack_bad == '0);
    a_ack_no_dup:   assert property (@(posedge clk) disable iff (!rst_n) !ack_dup);

endmodule

// File: tb/tb_toy_bpu_rob_mc.sv
// Directed bench for the fetch ROB: ordering, wrap, BP2 kill, flush drain and head skipping.
// Expected skip latency depends on whether TOY_BPU_ROB_SKIP2_EN is defined.
module tb_toy_bpu_rob_mc;

    localparam int DEPTH     = 8;
    localparam int DATA_W    = 128;
    localparam int ACK_PORTS = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    toy_bpu_rob_mc_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ACK_PORTS(ACK_PORTS)) bus ();

    toy_bpu_rob_mc #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ACK_PORTS(ACK_PORTS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] pld_of(input int id);
        return {4{32'hCAFE_0000 + 32'(id)}};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input logic a, input logic v0, input int id0,
                                 input logic v1, input int id1,
                                 input logic k, input logic f, input logic r);
        bus.alloc_req = a;
        bus.ack_vld   = {v1, v0};
        bus.ack_id    = {3'(id1), 3'(id0)};
        bus.ack_pld   = {pld_of(id1), pld_of(id0)};
        bus.bp2_vld   = k;
        bus.bp2_kill  = k;
        bus.flush     = f;
        bus.out_rdy   = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;

        // Reset values
        do_reset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_alloc_rdy", bus.alloc_rdy, 1);
        checkOutput("rst_alloc_id", bus.alloc_id, 0);
        checkOutput("rst_out_vld", bus.out_vld, 0);
        checkOutput("rst_out_pld", bus.out_pld, 0);
        checkOutput("rst_out_id", bus.out_id, 0);
        checkOutput("rst_flush_done", bus.flush_done, 1);
        checkOutput("rst_ack_rdy", bus.ack_rdy, 2'b11);

        // Out-of-order acks delivered in allocation order
        $display("[TB] in-order delivery");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
            checkOutput("ord_alloc_id", bus.alloc_id, i);
            tick();
        end
        applyStimulus(0, 0, 0, 1, 2, 0, 0, 1);
        checkOutput("ord_vld_before_ack0", bus.out_vld, 0);
        tick();
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 1);
        checkOutput("ord_vld_ack0_cycle", bus.out_vld, 0);
        tick();
        applyStimulus(0, 0, 0, 1, 1, 0, 0, 1);
        checkOutput("ord_vld0", bus.out_vld, 1);
        checkOutput("ord_id0", bus.out_id, 0);
        checkOutput("ord_pld0", bus.out_pld, pld_of(0));
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("ord_vld1", bus.out_vld, 1);
        checkOutput("ord_id1", bus.out_id, 1);
        checkOutput("ord_pld1", bus.out_pld, pld_of(1));
        tick();
        checkOutput("ord_vld2", bus.out_vld, 1);
        checkOutput("ord_id2", bus.out_id, 2);
        checkOutput("ord_pld2", bus.out_pld, pld_of(2));
        tick();
        checkOutput("ord_drained", bus.out_vld, 0);

        // Fill, full, wrap
        $display("[TB] fill and wrap");
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
            checkOutput("fill_rdy", bus.alloc_rdy, 1);
            checkOutput("fill_id", bus.alloc_id, i);
            tick();
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("full_rdy", bus.alloc_rdy, 0);
        tick();
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("full_head_vld", bus.out_vld, 1);
        checkOutput("full_head_id", bus.out_id, 0);
        checkOutput("full_head_rdy", bus.alloc_rdy, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("wrap_rdy", bus.alloc_rdy, 1);
        checkOutput("wrap_id", bus.alloc_id, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("wrap_full_again", bus.alloc_rdy, 0);
        checkOutput("wrap_head_id", bus.out_id, 1);
        checkOutput("wrap_head_vld", bus.out_vld, 0);

        // BP2 kill of the youngest entry
        $display("[TB] bp2 kill");
        do_reset();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 1);
        tick();
        applyStimulus(0, 1, 0, 1, 1, 0, 0, 1);
        checkOutput("kill_vld_early", bus.out_vld, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("kill_vld0", bus.out_vld, 1);
        checkOutput("kill_id0", bus.out_id, 0);
        checkOutput("kill_pld0", bus.out_pld, pld_of(0));
        tick();
        checkOutput("kill_no_out1", bus.out_vld, 0);
        tick();
        checkOutput("kill_no_out_after", bus.out_vld, 0);
        checkOutput("kill_head_at2", bus.out_id, 2);
        checkOutput("kill_alloc_id", bus.alloc_id, 2);
        checkOutput("kill_alloc_rdy", bus.alloc_rdy, 1);

        // Flush with outstanding fetches, orphan drain
        $display("[TB] flush drain");
        do_reset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("flush_blocks_alloc", bus.alloc_rdy, 0);
        tick();
        applyStimulus(0, 1, 0, 1, 2, 0, 0, 0);
        checkOutput("flush_done_low", bus.flush_done, 0);
        checkOutput("flush_out_vld", bus.out_vld, 0);
        tick();
        applyStimulus(0, 1, 3, 0, 0, 0, 0, 0);
        checkOutput("flush_done_last_pending", bus.flush_done, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("flush_done_high", bus.flush_done, 1);
        checkOutput("flush_out_vld_after", bus.out_vld, 0);
        checkOutput("flush_alloc_id", bus.alloc_id, 4);
        checkOutput("flush_alloc_rdy", bus.alloc_rdy, 1);

        // Alloc and kill in the same cycle
        $display("[TB] alloc with kill");
        do_reset();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0);
        tick();
        applyStimulus(0, 1, 0, 1, 1, 0, 0, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
            checkOutput("akill_no_out", bus.out_vld, 0);
            tick();
        end
        checkOutput("akill_head_at2", bus.out_id, 2);
        checkOutput("akill_flush_done", bus.flush_done, 1);

        // Killed heads in front of a DONE entry
        $display("[TB] killed head skipping");
        do_reset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 1, 0, 0);
            tick();
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 1, 3, 1, 2, 0, 0, 0);
        tick();
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        cyc = 0;
        while (!bus.out_vld && cyc < 8) begin
            tick();
            cyc++;
        end
`ifdef TOY_BPU_ROB_SKIP2_EN
        checkOutput("skip_cycles", cyc, 2);
`else
        checkOutput("skip_cycles", cyc, 3);
`endif
        checkOutput("skip_id", bus.out_id, 3);
        checkOutput("skip_pld", bus.out_pld, pld_of(3));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
